// File: rtl/uart_rx_fifo_if.sv
// Pop-side handshake between the UART receive FIFO and its consumer.
// The FIFO is the master: it presents the head byte and valid.
interface uart_rx_fifo_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Exposes occupancy, sticky overflow and a framing-error pulse.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        serial_in,
    uart_rx_fifo_if.master              rx_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic                        frame_err
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] SAMPLE_T = CW'(SAMPLE_TIME);
    localparam logic [CW-1:0] EDGE_T   = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT1     = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q;
    logic          frame_err_q, ferr_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          full, pop, accept;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = START;
            end
            START: begin
                if (cnt_q == SAMPLE_T) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == EDGE_T) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == EDGE_T) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign full   = (count_q == DEPTH);
    assign pop    = rx_if.data_out_valid & rx_if.data_out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept
    assign accept = push & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_q] <= shift_q;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (pop) rd_q <= rd_q + PTR_ONE;
            if (accept & ~pop) count_q <= count_q + CNT1;
            else if (pop & ~accept) count_q <= count_q - CNT1;
            if (push & ~accept) ovf_q <= 1'b1;
            else if (overflow_clr) ovf_q <= 1'b0;
        end
    end

    assign rx_if.data_out       = mem_q[rd_q];
    assign rx_if.data_out_valid = (count_q != '0);
    assign fifo_count           = count_q;
    assign overflow             = ovf_q;
    assign frame_err            = frame_err_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front-end that feeds the CPU's memory-stage MMIO read path. It deserialises 8N1 UART frames from serial_in and buffers completed bytes in a small first-word-fall-through FIFO. The memory stage pops bytes with a ready/valid handshake. Status flags expose FIFO occupancy, sticky overflow, and framing errors for the UART control register.

Parameters:
CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate.
FIFO_DEPTH, 8, byte entries; must be a power of two, minimum 2.

Ports:
clk  input  1  core clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
serial_in  input  1  UART line; idles high; asynchronous to clk.
data_out  output  8  byte at FIFO head; meaningful only while data_out_valid=1.
data_out_valid  output  1  FIFO non-empty.
data_out_ready  input  1  consumer pop request; a pop occurs when valid & ready.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
overflow  output  1  sticky flag: a received byte was dropped because the FIFO was full.
overflow_clr  input  1  clears overflow; set has priority if both occur in the same cycle.
frame_err  output  1  one-cycle pulse when a stop bit samples low.

Behaviour:
- Derived constants: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division); SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
- Input synchroniser: 2-flop, both flops reset to 1. All FSM decisions use the synchronised bit only.
- FSM states: IDLE, START, DATA, STOP, BREAK. A bit-period counter and a 3-bit bit index support the FSM.
- IDLE: when the synchronised line is 0, go to START and clear the counter.
- START: at counter==SAMPLE_TIME, resample the line. If 0, go to DATA and clear the counter and bit index. If 1, this is a false start: return to IDLE with no push and no error.
- DATA: every SYMBOL_EDGE_TIME cycles, sample into the shift register LSB first. After bit index 7 is sampled, go to STOP.
- STOP: sample after SYMBOL_EDGE_TIME cycles.
  - If 1, push the byte and go to IDLE.
  - If 0, pulse frame_err for 1 cycle, drop the byte, and go to BREAK.
- BREAK: stay until the line reads 1, then go to IDLE. This prevents a held-low line from producing spurious frames.
- Push latency: the byte becomes visible on data_out / data_out_valid the cycle after the stop-bit sample.
- FIFO: circular buffer with read/write pointers and a count register; first-word-fall-through.
  - data_out = mem[rd_ptr]; data_out_valid = (count != 0).
  - Pointers wrap modulo FIFO_DEPTH.
- Push when full with no pop in the same cycle: byte dropped, overflow set, count unchanged.
- Push when full with a pop in the same cycle: the push is accepted and count stays at FIFO_DEPTH.
- Pop when empty: ignored; no pointer change.
- Simultaneous push and pop when non-empty: count unchanged; both pointers advance.
- Reset values (asynchronous, any state including mid-frame): FSM=IDLE; counters=0; pointers=0; fifo_count=0; data_out_valid=0; overflow=0; frame_err=0; synchroniser=1; data_out=0. A frame cut by reset is discarded. The receiver resumes on the next falling edge seen after reset deasserts.
- data_out_ready is a level signal with no registered state. A consumer holding it high pops one byte per cycle while valid.

Test Plan:
- Single frame, with CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles/bit): send 0xA5 -> data_out=0xA5 and valid=1 one cycle after the stop sample; fifo_count=1. Assert ready for 1 cycle -> valid=0, count=0.
- False start: pulse serial_in low for 3 cycles -> no push, no frame_err, FSM back in IDLE. Then send 0x3C -> 0x3C received correctly.
- Framing error: send 0x55 with stop bit 0 and the line held low 40 cycles -> one frame_err pulse, count=0. After the line returns high, send 0x0F -> 0x0F received.
- Overflow with FIFO_DEPTH=4: send 0x01..0x05 with ready=0 -> count=4, head=0x01, overflow=1. Pulse overflow_clr -> overflow=0. Pop 4 -> outputs 0x01,0x02,0x03,0x04 in order.
- Full plus simultaneous pop: fill 4 entries, hold ready=1 on the cycle 0x09 is pushed -> count stays 4, overflow stays 0, 0x09 is the last byte out.
- Reset mid-frame: assert rst during DATA bit 4 of 0xFF with 2 bytes queued -> count=0, valid=0, overflow=0 immediately. After release, send 0x81 -> only 0x81 received.
